// File: rtl/io_bus_bridge_if.sv
// CPU-side memory port, RAM port, UART TX/RX handshakes and status flags of the I/O bus bridge.
interface io_bus_bridge_if #(
  parameter int unsigned RAM_ADDR_W = 17
);
  logic                  rdy_in;
  logic [31:0]           cpu_a;
  logic                  cpu_wr;
  logic [7:0]            cpu_wdata;
  logic [7:0]            cpu_rdata;
  logic                  io_buffer_full;
  logic [RAM_ADDR_W-1:0] ram_a;
  logic                  ram_we;
  logic [7:0]            ram_wdata;
  logic [7:0]            ram_rdata;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  logic                  rx_empty;
  logic [7:0]            rx_data;
  logic                  rx_pop;
  logic                  program_halt;
  logic                  tx_overflow;

  modport slave (
    input  rdy_in, cpu_a, cpu_wr, cpu_wdata, ram_rdata, tx_ready, rx_empty, rx_data,
    output cpu_rdata, io_buffer_full, ram_a, ram_we, ram_wdata, tx_valid, tx_data, rx_pop,
           program_halt, tx_overflow
  );

  modport master (
    output rdy_in, cpu_a, cpu_wr, cpu_wdata, ram_rdata, tx_ready, rx_empty, rx_data,
    input  cpu_rdata, io_buffer_full, ram_a, ram_we, ram_wdata, tx_valid, tx_data, rx_pop,
           program_halt, tx_overflow
  );
endinterface

// File: rtl/io_bus_bridge.sv
// Decodes cpu byte accesses to block RAM or the I/O window at 0x30000 and owns the UART TX FIFO,
// RX pop, cycle counter with coherent snapshot, and the sticky program-halt flag.
module io_bus_bridge #(
  parameter int unsigned RAM_ADDR_W   = 17,
  parameter int unsigned TX_DEPTH_LOG = 3,
  parameter int unsigned FULL_MARGIN  = 2
) (
  input logic         clk_in,
  input logic         rst_in,
  io_bus_bridge_if.slave bus
);

  localparam int unsigned Depth = 1 << TX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0]   CntDepth  = (TX_DEPTH_LOG + 1)'(Depth);
  localparam logic [TX_DEPTH_LOG:0]   CntThresh = (TX_DEPTH_LOG + 1)'(Depth - FULL_MARGIN);
  localparam logic [TX_DEPTH_LOG:0]   CntOne    = (TX_DEPTH_LOG + 1)'(1);
  localparam logic [TX_DEPTH_LOG-1:0] PtrOne    = TX_DEPTH_LOG'(1);

  typedef enum logic [1:0] {SelRam, SelIo, SelCnt} sel_e;

  logic [17:0] addr;
  logic        is_io, is_rx, is_cnt, is_halt;
  logic        rd_req, wr_req;
  logic        unused_addr;

  assign addr        = bus.cpu_a[17:0];
  assign unused_addr = ^bus.cpu_a[31:18];
  assign is_io       = (addr[17:16] == 2'b11);
  assign is_rx       = (addr == 18'h30000);
  assign is_cnt      = (addr[17:2] == 16'hC001);
  assign is_halt     = (addr == 18'h30004);
  assign rd_req      = bus.rdy_in & ~bus.cpu_wr;
  assign wr_req      = bus.rdy_in & bus.cpu_wr;

  assign bus.ram_a     = bus.cpu_a[RAM_ADDR_W-1:0];
  assign bus.ram_wdata = bus.cpu_wdata;
  assign bus.ram_we    = wr_req & ~is_io;

  // TX FIFO
  logic [7:0]              mem_q [Depth];
  logic [TX_DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
  logic [TX_DEPTH_LOG:0]   cnt_q, cnt_d;
  logic                    full_q, ovf_q, halt_q;
  logic                    push_req, push, pop, fifo_full;

  assign fifo_full = (cnt_q == CntDepth);
  assign pop       = (cnt_q != '0) & bus.tx_ready;
  assign push_req  = wr_req & is_rx & (bus.cpu_wdata != 8'h00);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal then.
  assign push      = push_req & (~fifo_full | pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CntOne;
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= bus.cpu_wdata;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d >= CntThresh);
      if (push_req && fifo_full && !pop) ovf_q <= 1'b1;
      if (wr_req && is_halt) halt_q <= 1'b1;
    end
  end

  assign bus.tx_valid       = (cnt_q != '0);
  assign bus.tx_data        = mem_q[rd_ptr_q];
  assign bus.io_buffer_full = full_q;
  assign bus.tx_overflow    = ovf_q;
  assign bus.program_halt   = halt_q;

  // Read path
  sel_e        sel_q, sel_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  io_q, io_d;
  logic [31:0] cycle_q, snap_q, snap_d;
  logic        fresh_q, rx_pop_q;
  logic [7:0]  hold_q, rd_mux, rdata;

  always_comb begin
    sel_d  = sel_q;
    byte_d = byte_q;
    io_d   = io_q;
    snap_d = snap_q;
    if (rd_req) begin
      byte_d = addr[1:0];
      if (!is_io) begin
        sel_d = SelRam;
      end else if (is_cnt) begin
        sel_d = SelCnt;
        // Byte 0 freezes the whole dword so bytes 1..3 read back coherently.
        if (addr[1:0] == 2'b00) snap_d = cycle_q;
      end else begin
        sel_d = SelIo;
        io_d  = (is_rx && !bus.rx_empty) ? bus.rx_data : 8'h00;
      end
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (sel_q)
      SelRam:  rd_mux = bus.ram_rdata;
      SelIo:   rd_mux = io_q;
      SelCnt:  rd_mux = snap_q[{byte_q, 3'b000} +: 8];
      default: rd_mux = 8'h00;
    endcase
  end

  // Without a fresh read the last returned byte is held.
  assign rdata         = fresh_q ? rd_mux : hold_q;
  assign bus.cpu_rdata = rdata;
  assign bus.rx_pop    = rx_pop_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sel_q    <= SelRam;
      byte_q   <= 2'b00;
      io_q     <= 8'h00;
      snap_q   <= '0;
      cycle_q  <= '0;
      fresh_q  <= 1'b0;
      hold_q   <= 8'h00;
      rx_pop_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      byte_q   <= byte_d;
      io_q     <= io_d;
      snap_q   <= snap_d;
      fresh_q  <= rd_req;
      hold_q   <= rdata;
      rx_pop_q <= rd_req & is_rx & ~bus.rx_empty;
      if (bus.rdy_in && !halt_q) cycle_q <= cycle_q + 32'd1;
    end
  end

endmodule
